retire_trace_buffer: RTL and testbench
======================================

Name: retire_trace_buffer

Overview:
Synthesizable retirement-trace collector that sits directly downstream of the core's writeback and LSU store stages and consumes their retirement events. Each cycle it turns register writes, jumps, taken branches and stores into fixed-format trace records and queues them in a FIFO. Records drain over a valid/ready port to a host or DMA. The block also provides the cycle counter, the finish-address detector and the no-retire watchdog, which makes it usable on FPGA as well as in simulation.

Parameters:
XLEN, 32, datapath width
DEPTH, 16, FIFO entries; power of 2, minimum 4
FINISH_ADDR, 32'h1000_0000, store address that ends the trace
WDOG_LIMIT, 1000, idle cycles before hang is flagged

Ports:
clk  in  1  core clock
rst_n  in  1  reset
wb_rd_wr_en  in  1  register write retiring
wb_pc_load  in  1  redirect accompanies wb (JAL/JALR)
wb_tag  in  XLEN  instruction PC
wb_instr  in  32  instruction word
wb_rd_addr  in  5  destination register
wb_data  in  XLEN  written value
br_taken  in  1  conditional branch taken, no rd write
br_tag  in  XLEN  branch PC
br_instr  in  32  branch word
pc_exu  in  XLEN  redirect target
st_valid  in  1  store retiring (legal & store)
st_tag  in  XLEN  store PC
st_instr  in  32  store word
st_addr  in  XLEN  store address
st_data  in  XLEN  masked store data
trc_valid  out  1  record available
trc_ready  in  1  consumer accepts
trc_rec  out  trace_rec_t  head record
cycle_count  out  32  cycles since reset release
finish  out  1  sticky: finish store captured
hang  out  1  sticky: watchdog expired
overflow  out  1  sticky: a record was dropped
drop_count  out  16  dropped records, saturating

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous, active-low. While reset is asserted all outputs are 0, the FIFO is empty, and every counter and sticky flag is cleared.
- cycle_count increments by 1 every cycle after rst_n is released and wraps at 2^32.
- Record kinds:
  - REG: wb_rd_wr_en & ~wb_pc_load.
  - JUMP: wb_rd_wr_en & wb_pc_load; the pc field takes pc_exu.
  - BRANCH: br_taken; the pc field takes pc_exu.
  - STORE: st_valid; the addr field takes st_addr and the data field takes st_data.
- Each record stamps cycle_count as of the capture cycle.
- Per cycle the block can create up to 2 records: one from wb, or from br when wb is idle, plus one STORE. wb and br both valid in the same cycle is illegal; wb wins.
- Push order within a cycle: the wb/br record first, then STORE. Records land in the FIFO one cycle after the inputs.
- Dropping: if free slots are fewer than the records created, the block pushes as many as fit, in order, and drops the rest. Each dropped record sets overflow and increments drop_count, which saturates at 16'hFFFF.
- Simultaneous pop: a pop in the same cycle frees its slot before the space check, so a full FIFO with trc_ready=1 accepts 1 new record.
- Drain handshake: trc_valid = ~empty, and the transfer occurs when trc_valid & trc_ready. trc_rec holds stable while trc_valid=1 and trc_ready=0. Wrap-around uses log2(DEPTH)+1 bit pointers.
- Finish: a STORE with st_addr == FINISH_ADDR is captured, subject to space, and sets finish on the next cycle. Once finish=1, capture stops entirely, but the FIFO keeps draining.
- Watchdog: the idle counter resets to 0 on any wb, br or st event and otherwise increments. When it exceeds WDOG_LIMIT, hang is set (sticky) and the counter freezes. The watchdog is disabled once finish=1.
- Reset mid-operation: queued records are discarded and trc_valid drops asynchronously.

Decomposition:
- Package trace_pkg:
  - trace_kind_e (REG=0, JUMP=1, BRANCH=2, STORE=3).
  - trace_rec_t {kind, cycle[31:0], tag[XLEN-1:0], instr[31:0], rd[4:0], addr[XLEN-1:0], data[XLEN-1:0], pc[XLEN-1:0]}; unused fields are 0.
  - Defaults for FINISH_ADDR and WDOG_LIMIT.
- Sub-module trace_fifo: dual-push, single-pop synchronous FIFO that reports free-slot count.

Test Plan:
- REG event: tag 0x100, rd 5, data 0xDEAD_BEEF at cycle 20 → next cycle trc_valid=1, kind REG, cycle=20, rd=5, data=0xDEADBEEF.
- Same-cycle JUMP and STORE: JUMP (pc_exu 0x200) plus STORE (addr 0x80, data 0x12) → two records, JUMP first then STORE, both with the same cycle stamp.
- Backpressure: trc_ready=0 with DEPTH+3 events → FIFO full, overflow=1, drop_count=3, trc_rec stable. Release trc_ready → DEPTH records drain in order.
- Finish: STORE to 0x1000_0000 → finish=1 next cycle. A later REG event is not captured, and the finish record drains.
- Watchdog: no events for 1001 cycles after reset → hang=1. A single event at cycle 500 delays hang to cycle 1501.
- Async reset: assert rst_n=0 mid-drain with the FIFO holding 5 entries → trc_valid=0 immediately, cycle_count=0, flags cleared.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and defaults for the retirement trace collector.
package trace_pkg;

    localparam int unsigned            TRC_XLEN        = 32;
    localparam logic [TRC_XLEN-1:0]    TRC_FINISH_ADDR = 32'h1000_0000;
    localparam int unsigned            TRC_WDOG_LIMIT  = 1000;

    typedef enum logic [1:0] {
        REG    = 2'd0,
        JUMP   = 2'd1,
        BRANCH = 2'd2,
        STORE  = 2'd3
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e          kind;
        logic [31:0]          cycle;
        logic [TRC_XLEN-1:0]  tag;
        logic [31:0]          instr;
        logic [4:0]           rd;
        logic [TRC_XLEN-1:0]  addr;
        logic [TRC_XLEN-1:0]  data;
        logic [TRC_XLEN-1:0]  pc;
    } trace_rec_t;

    // Zeroed record carrying only the capture-cycle stamp.
    function automatic trace_rec_t trc_blank(input logic [31:0] stamp);
        trace_rec_t rec;
        rec       = '0;
        rec.cycle = stamp;
        return rec;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Dual-push, single-pop synchronous FIFO of trace records with a free-slot count.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     i_push_cnt,
    input  trace_rec_t     i_din0,
    input  trace_rec_t     i_din1,
    input  logic           i_pop,
    output trace_rec_t     o_dout,
    output logic           o_empty,
    output logic [CW-1:0]  o_free
);

    trace_rec_t      r_mem [DEPTH];
    logic [CW-1:0]   r_wr;
    logic [CW-1:0]   r_rd;
    logic [CW-1:0]   w_count;
    logic [AW-1:0]   w_wr_idx0;
    logic [AW-1:0]   w_wr_idx1;

    assign w_count   = r_wr - r_rd;
    assign w_wr_idx0 = r_wr[AW-1:0];
    assign w_wr_idx1 = w_wr_idx0 + AW'(1);
    assign o_empty   = (r_wr == r_rd);
    assign o_free    = CW'(DEPTH) - w_count;
    // Head is forced to zero when empty so reset and idle present a clean record.
    assign o_dout    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk) begin
        if (i_push_cnt != 2'd0) begin
            r_mem[w_wr_idx0] <= i_din0;
        end
        if (i_push_cnt == 2'd2) begin
            r_mem[w_wr_idx1] <= i_din1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr <= r_wr + CW'(i_push_cnt);
            if (i_pop && !o_empty) begin
                r_rd <= r_rd + CW'(1);
            end
        end
    end

endmodule

// File: rtl/retire_trace_buffer.sv
// Turns writeback/branch/store retirement events into trace records, queues them
// for a valid/ready consumer, and tracks cycle count, finish and a no-retire watchdog.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned       XLEN        = TRC_XLEN,
    parameter int unsigned       DEPTH       = 16,
    parameter logic [XLEN-1:0]   FINISH_ADDR = TRC_FINISH_ADDR,
    parameter int unsigned       WDOG_LIMIT  = TRC_WDOG_LIMIT
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_rd_wr_en,
    input  logic             wb_pc_load,
    input  logic [XLEN-1:0]  wb_tag,
    input  logic [31:0]      wb_instr,
    input  logic [4:0]       wb_rd_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_tag,
    input  logic [31:0]      br_instr,
    input  logic [XLEN-1:0]  pc_exu,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_tag,
    input  logic [31:0]      st_instr,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             trc_valid,
    input  logic             trc_ready,
    output trace_rec_t       trc_rec,
    output logic [31:0]      cycle_count,
    output logic             finish,
    output logic             hang,
    output logic             overflow,
    output logic [15:0]      drop_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned IW = $clog2(WDOG_LIMIT + 2);

    logic             w_a_vld;
    logic             w_b_vld;
    logic             w_finish_hit;
    logic             w_any_evt;
    logic             w_empty;
    logic             w_pop;
    logic [CW-1:0]    w_free;
    logic [CW-1:0]    w_free_eff;
    logic [1:0]       w_n_new;
    logic [1:0]       w_push_cnt;
    logic [1:0]       w_n_drop;
    logic [16:0]      w_drop_sum;
    logic [IW-1:0]    w_idle_cur;
    logic [IW-1:0]    w_idle_inc;
    trace_rec_t       w_rec_a;
    trace_rec_t       w_rec_b;
    trace_rec_t       w_din0;
    trace_rec_t       w_din1;

    logic [31:0]      r_cycle;
    logic             r_finish;
    logic             r_hang;
    logic             r_overflow;
    logic [15:0]      r_drop;
    logic [IW-1:0]    r_idle;

    // Capture stops entirely once the finish store has been seen.
    assign w_a_vld      = ~r_finish & (wb_rd_wr_en | br_taken);
    assign w_b_vld      = ~r_finish & st_valid;
    assign w_finish_hit = w_b_vld & (st_addr == FINISH_ADDR);
    assign w_any_evt    = wb_rd_wr_en | br_taken | st_valid;

    // Writeback/branch record; wb wins if both are (illegally) present.
    always_comb begin
        w_rec_a = trc_blank(r_cycle);
        if (wb_rd_wr_en) begin
            w_rec_a.kind  = wb_pc_load ? JUMP : REG;
            w_rec_a.tag   = TRC_XLEN'(wb_tag);
            w_rec_a.instr = wb_instr;
            w_rec_a.rd    = wb_rd_addr;
            w_rec_a.data  = TRC_XLEN'(wb_data);
            if (wb_pc_load) begin
                w_rec_a.pc = TRC_XLEN'(pc_exu);
            end
        end else begin
            w_rec_a.kind  = BRANCH;
            w_rec_a.tag   = TRC_XLEN'(br_tag);
            w_rec_a.instr = br_instr;
            w_rec_a.pc    = TRC_XLEN'(pc_exu);
        end
    end

    always_comb begin
        w_rec_b       = trc_blank(r_cycle);
        w_rec_b.kind  = STORE;
        w_rec_b.tag   = TRC_XLEN'(st_tag);
        w_rec_b.instr = st_instr;
        w_rec_b.addr  = TRC_XLEN'(st_addr);
        w_rec_b.data  = TRC_XLEN'(st_data);
    end

    // A same-cycle pop frees its slot before the space check.
    assign trc_valid  = ~w_empty;
    assign w_pop      = trc_valid & trc_ready;
    assign w_free_eff = w_free + CW'(w_pop);
    assign w_n_new    = 2'(w_a_vld) + 2'(w_b_vld);

    always_comb begin
        w_push_cnt = w_n_new;
        if (w_free_eff < CW'(w_n_new)) begin
            w_push_cnt = w_free_eff[1:0];
        end
    end

    assign w_n_drop   = w_n_new - w_push_cnt;
    assign w_din0     = w_a_vld ? w_rec_a : w_rec_b;
    assign w_din1     = w_rec_b;
    assign w_drop_sum = 17'(r_drop) + 17'(w_n_drop);

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_cnt (w_push_cnt),
        .i_din0     (w_din0),
        .i_din1     (w_din1),
        .i_pop      (w_pop),
        .o_dout     (trc_rec),
        .o_empty    (w_empty),
        .o_free     (w_free)
    );

    // An event zeroes the idle count for its own cycle, so the count tracks cycles since it.
    assign w_idle_cur = w_any_evt ? '0 : r_idle;
    assign w_idle_inc = w_idle_cur + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle    <= '0;
            r_finish   <= 1'b0;
            r_hang     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop     <= '0;
            r_idle     <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_finish_hit) begin
                r_finish <= 1'b1;
            end
            if (w_n_drop != 2'd0) begin
                r_overflow <= 1'b1;
                r_drop     <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
            // Watchdog freezes once it fires and is disabled after finish.
            if (!r_finish && !r_hang) begin
                r_idle <= w_idle_inc;
                if (32'(w_idle_inc) > WDOG_LIMIT) begin
                    r_hang <= 1'b1;
                end
            end
        end
    end

    assign cycle_count = r_cycle;
    assign finish      = r_finish;
    assign hang        = r_hang;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer against a queue-based reference model.
module tb_retire_trace_buffer;
    import trace_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LIMIT = 1000;
    localparam logic [31:0] FIN   = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_rd_wr_en, wb_pc_load, br_taken, st_valid, trc_ready;
    logic [31:0] wb_tag, wb_instr, wb_data, br_tag, br_instr, pc_exu;
    logic [4:0]  wb_rd_addr;
    logic [31:0] st_tag, st_instr, st_addr, st_data;
    logic        trc_valid, finish, hang, overflow;
    trace_rec_t  trc_rec;
    logic [31:0] cycle_count;
    logic [15:0] drop_count;

    int vectors = 0;
    int errors  = 0;

    trace_rec_t  m_q[$];
    logic [31:0] m_cycle;
    logic [31:0] m_last_evt;
    bit          m_finish, m_hang, m_overflow;
    int unsigned m_drop;

    retire_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .FINISH_ADDR(FIN), .WDOG_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_rd_wr_en(wb_rd_wr_en), .wb_pc_load(wb_pc_load), .wb_tag(wb_tag),
        .wb_instr(wb_instr), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .br_taken(br_taken), .br_tag(br_tag), .br_instr(br_instr), .pc_exu(pc_exu),
        .st_valid(st_valid), .st_tag(st_tag), .st_instr(st_instr),
        .st_addr(st_addr), .st_data(st_data),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_rec(trc_rec),
        .cycle_count(cycle_count), .finish(finish), .hang(hang),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        wb_rd_wr_en = 0; wb_pc_load = 0; wb_tag = 0; wb_instr = 0; wb_rd_addr = 0; wb_data = 0;
        br_taken = 0; br_tag = 0; br_instr = 0; pc_exu = 0;
        st_valid = 0; st_tag = 0; st_instr = 0; st_addr = 0; st_data = 0;
    endtask

    task automatic set_wb(input bit jump, input logic [31:0] tag, input logic [4:0] rd,
                          input logic [31:0] data, input logic [31:0] tgt);
        wb_rd_wr_en = 1; wb_pc_load = jump; wb_tag = tag; wb_instr = $urandom;
        wb_rd_addr = rd; wb_data = data; pc_exu = tgt;
    endtask

    task automatic set_st(input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1; st_tag = $urandom; st_instr = $urandom; st_addr = addr; st_data = data;
    endtask

    // Reference model: what one clock edge does given the inputs now on the pins.
    task automatic model_step();
        trace_rec_t r;
        trace_rec_t nw[$];
        if (trc_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (!m_finish) begin
            if (wb_rd_wr_en) begin
                r = '0; r.kind = wb_pc_load ? JUMP : REG; r.cycle = m_cycle; r.tag = wb_tag;
                r.instr = wb_instr; r.rd = wb_rd_addr; r.data = wb_data;
                r.pc = wb_pc_load ? pc_exu : 32'h0;
                nw.push_back(r);
            end else if (br_taken) begin
                r = '0; r.kind = BRANCH; r.cycle = m_cycle; r.tag = br_tag;
                r.instr = br_instr; r.pc = pc_exu;
                nw.push_back(r);
            end
            if (st_valid) begin
                r = '0; r.kind = STORE; r.cycle = m_cycle; r.tag = st_tag; r.instr = st_instr;
                r.addr = st_addr; r.data = st_data;
                nw.push_back(r);
            end
            foreach (nw[i]) begin
                if (m_q.size() < DEPTH) m_q.push_back(nw[i]);
                else begin
                    m_overflow = 1;
                    if (m_drop < 32'hFFFF) m_drop++;
                end
            end
            if (wb_rd_wr_en || br_taken || st_valid) m_last_evt = m_cycle;
            if ((m_cycle + 32'd1 - m_last_evt) > LIMIT) m_hang = 1;
            if (st_valid && st_addr == FIN) m_finish = 1;
        end
        m_cycle = m_cycle + 32'd1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        trc_ready = 0;
        m_q.delete(); m_cycle = 0; m_last_evt = 0;
        m_finish = 0; m_hang = 0; m_overflow = 0; m_drop = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs(); trc_ready = 1;
        #12;
        vectors++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", trc_valid); end
        vectors++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle got=%0d exp=0", cycle_count); end
        vectors++; if ({finish, hang, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {finish, hang, overflow}); end
        vectors++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        vectors++; if (trc_rec !== '0) begin errors++; $display("FAIL reset_rec got=%h exp=0", trc_rec); end
    endtask

    task automatic test_watchdog();
        do_reset(); trc_ready = 1;
        for (int i = 0; i < 1004; i++) begin
            vectors++; if (cycle_count !== m_cycle) begin errors++; $display("FAIL wdog_cycle got=%0d exp=%0d", cycle_count, m_cycle); end
            vectors++; if (hang !== m_hang) begin errors++; $display("FAIL wdog_idle_model cyc=%0d got=%0b exp=%0b", m_cycle, hang, m_hang); end
            vectors++; if (hang !== (m_cycle >= 32'd1001)) begin errors++; $display("FAIL wdog_idle_1001 cyc=%0d got=%0b", m_cycle, hang); end
            tick();
        end
        do_reset(); trc_ready = 1;
        for (int i = 0; i < 1505; i++) begin
            clear_inputs();
            if (m_cycle == 32'd500) set_wb(0, 32'h44, 5'd1, 32'h1, 32'h0);
            vectors++; if (hang !== m_hang) begin errors++; $display("FAIL wdog_evt_model cyc=%0d got=%0b exp=%0b", m_cycle, hang, m_hang); end
            vectors++; if (hang !== (m_cycle >= 32'd1501)) begin errors++; $display("FAIL wdog_evt_1501 cyc=%0d got=%0b", m_cycle, hang); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reg();
        do_reset(); trc_ready = 0;
        while (m_cycle != 32'd20) tick();
        set_wb(0, 32'h100, 5'd5, 32'hDEAD_BEEF, 32'h0);
        tick(); clear_inputs();
        vectors++; if (trc_valid !== 1'b1) begin errors++; $display("FAIL reg_valid got=%0b exp=1", trc_valid); end
        vectors++; if (trc_rec.kind !== REG) begin errors++; $display("FAIL reg_kind got=%0d exp=0", trc_rec.kind); end
        vectors++; if (trc_rec.cycle !== 32'd20) begin errors++; $display("FAIL reg_cycle got=%0d exp=20", trc_rec.cycle); end
        vectors++; if (trc_rec.rd !== 5'd5 || trc_rec.tag !== 32'h100) begin errors++; $display("FAIL reg_rd_tag got=%0d/%h exp=5/100", trc_rec.rd, trc_rec.tag); end
        vectors++; if (trc_rec.data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL reg_data got=%h exp=deadbeef", trc_rec.data); end
        vectors++; if (trc_rec !== m_q[0]) begin errors++; $display("FAIL reg_rec got=%h exp=%h", trc_rec, m_q[0]); end
        trc_ready = 1; tick();
        vectors++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL reg_drained got=%0b exp=0", trc_valid); end
    endtask

    task automatic test_jump_store();
        logic [31:0] stamp;
        do_reset(); trc_ready = 0;
        repeat (3) tick();
        stamp = m_cycle;
        set_wb(1, 32'h300, 5'd1, 32'h304, 32'h200);
        set_st(32'h80, 32'h12);
        tick(); clear_inputs();
        vectors++; if (trc_rec.kind !== JUMP || trc_rec.pc !== 32'h200) begin errors++; $display("FAIL js_first got=%0d/%h exp=1/200", trc_rec.kind, trc_rec.pc); end
        vectors++; if (trc_rec !== m_q[0]) begin errors++; $display("FAIL js_first_rec got=%h exp=%h", trc_rec, m_q[0]); end
        trc_ready = 1; tick();
        vectors++; if (trc_rec.kind !== STORE || trc_rec.addr !== 32'h80 || trc_rec.data !== 32'h12) begin errors++; $display("FAIL js_second got=%0d/%h/%h exp=3/80/12", trc_rec.kind, trc_rec.addr, trc_rec.data); end
        vectors++; if (trc_rec.cycle !== stamp) begin errors++; $display("FAIL js_stamp got=%0d exp=%0d", trc_rec.cycle, stamp); end
        tick();
        vectors++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL js_drained got=%0b exp=0", trc_valid); end
    endtask

    task automatic test_backpressure();
        trace_rec_t head;
        do_reset(); trc_ready = 0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            clear_inputs();
            set_wb(0, $urandom, 5'($urandom), $urandom, 32'h0);
            tick();
            if (i == 0) head = trc_rec;
            vectors++; if (trc_rec !== head) begin errors++; $display("FAIL bp_stable i=%0d got=%h exp=%h", i, trc_rec, head); end
        end
        clear_inputs();
        vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got=%0b exp=1", overflow); end
        vectors++; if (drop_count !== 16'd3) begin errors++; $display("FAIL bp_drop got=%0d exp=3", drop_count); end
        // Full with a pop: exactly one of two new records fits.
        trc_ready = 1;
        set_wb(1, 32'h500, 5'd2, 32'h504, 32'h600);
        set_st(32'h90, 32'h34);
        tick(); clear_inputs();
        vectors++; if (drop_count !== 16'd4) begin errors++; $display("FAIL bp_fullpop_drop got=%0d exp=4", drop_count); end
        for (int i = 0; i < 2 * DEPTH && m_q.size() > 0; i++) begin
            vectors++; if (trc_rec !== m_q[0]) begin errors++; $display("FAIL bp_drain i=%0d got=%h exp=%h", i, trc_rec, m_q[0]); end
            tick();
        end
        vectors++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%0b exp=0", trc_valid); end
    endtask

    task automatic test_finish();
        do_reset(); trc_ready = 0;
        tick();
        set_st(FIN, 32'h1);
        tick(); clear_inputs();
        vectors++; if (finish !== 1'b1) begin errors++; $display("FAIL fin_flag got=%0b exp=1", finish); end
        set_wb(0, 32'h700, 5'd7, 32'h77, 32'h0);
        tick(); clear_inputs();
        trc_ready = 1;
        vectors++; if (trc_rec.kind !== STORE || trc_rec.addr !== FIN) begin errors++; $display("FAIL fin_rec got=%0d/%h exp=3/%h", trc_rec.kind, trc_rec.addr, FIN); end
        tick();
        vectors++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL fin_no_capture got=%0b exp=0", trc_valid); end
        vectors++; if (finish !== 1'b1) begin errors++; $display("FAIL fin_sticky got=%0b exp=1", finish); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            clear_inputs();
            trc_ready = ($urandom_range(0, 9) < 5);
            if ($urandom_range(0, 9) < 4) set_wb($urandom_range(0, 3) == 0, $urandom, 5'($urandom), $urandom, $urandom);
            if ($urandom_range(0, 9) < 3) begin br_taken = 1; br_tag = $urandom; br_instr = $urandom; pc_exu = $urandom; end
            if ($urandom_range(0, 9) < 4) set_st({16'h0, 16'($urandom)}, $urandom);
            vectors++; if (trc_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid i=%0d got=%0b exp=%0b", i, trc_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                vectors++; if (trc_rec !== m_q[0]) begin errors++; $display("FAIL rnd_rec i=%0d got=%h exp=%h", i, trc_rec, m_q[0]); end
            end
            vectors++; if (drop_count !== 16'(m_drop) || overflow !== m_overflow) begin errors++; $display("FAIL rnd_drop i=%0d got=%0d/%0b exp=%0d/%0b", i, drop_count, overflow, m_drop, m_overflow); end
            vectors++; if (cycle_count !== m_cycle) begin errors++; $display("FAIL rnd_cycle i=%0d got=%0d exp=%0d", i, cycle_count, m_cycle); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset(); trc_ready = 0;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            set_wb(0, $urandom, 5'($urandom), $urandom, 32'h0);
            tick();
        end
        clear_inputs();
        vectors++; if (trc_valid !== 1'b1) begin errors++; $display("FAIL ar_loaded got=%0b exp=1", trc_valid); end
        trc_ready = 1; tick();
        #2 rst_n = 0;
        #1;
        vectors++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%0b exp=0", trc_valid); end
        vectors++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL ar_cycle got=%0d exp=0", cycle_count); end
        vectors++; if ({finish, hang, overflow} !== 3'b000 || drop_count !== 16'd0) begin errors++; $display("FAIL ar_flags got=%b/%0d exp=000/0", {finish, hang, overflow}, drop_count); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_watchdog();
        test_reg();
        test_jump_store();
        test_backpressure();
        test_finish();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
